// File: rtl/arith_interval_coder.sv
// Arithmetic-coding interval engine: narrows [low, high] per (lower, upper, total) triple and emits renormalization bits.
// Latency: CODE_BITS+1 divide cycles + 1 update + 1 per renorm test + >=1 per emitted bit; illegal triple costs 1 cycle.
// Backpressure: ready_out high only in IDLE; each coded bit holds on bit_out/bit_valid_out until bit_ready_in takes it.
//
// Ports:
//   clk, rst (async, active-low)
//   lower_bound_in/upper_bound_in/range_in/valid_in/ready_out : symbol triple handshake
//   flush_in                                                  : end-of-stream request (IDLE, valid_in low)
//   bit_out/bit_valid_out/bit_ready_in                        : coded bitstream handshake
//   done_out                                                  : one-cycle pulse when flush tail is taken
//   error_out                                                 : sticky illegal-triple flag
module arith_interval_coder #(
    parameter int CODE_BITS = 32,
    parameter int FREQ_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FREQ_BITS-1:0] lower_bound_in,
    input  logic [FREQ_BITS-1:0] upper_bound_in,
    input  logic [FREQ_BITS-1:0] range_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic                 flush_in,
    output logic                 bit_out,
    output logic                 bit_valid_out,
    input  logic                 bit_ready_in,
    output logic                 done_out,
    output logic                 error_out
);

    localparam int CW = $clog2(CODE_BITS + 1);
    localparam logic [CODE_BITS-1:0] HALF     = {1'b1, {(CODE_BITS-1){1'b0}}};
    localparam logic [CODE_BITS-1:0] QUARTER  = {2'b01, {(CODE_BITS-2){1'b0}}};
    localparam logic [CODE_BITS-1:0] THREE_Q  = {2'b11, {(CODE_BITS-2){1'b0}}};
    localparam logic [CODE_BITS-1:0] ALL_ONES = {CODE_BITS{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIVIDE,
        S_UPDATE,
        S_RENORM,
        S_EMIT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [CODE_BITS-1:0]   low, low_nxt;
    logic [CODE_BITS-1:0]   high, high_nxt;
    logic [CODE_BITS-1:0]   pending, pending_nxt;
    logic [FREQ_BITS-1:0]   lo_f, lo_f_nxt;
    logic [FREQ_BITS-1:0]   hi_f, hi_f_nxt;
    logic [FREQ_BITS-1:0]   tot_f, tot_f_nxt;
    // Dividend is one bit wider than the code: the full initial range is 2^CODE_BITS.
    logic [CODE_BITS:0]     dvd, dvd_nxt;
    logic [CODE_BITS:0]     quot, quot_nxt;
    logic [FREQ_BITS-1:0]   rem, rem_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   cur_bit, cur_bit_nxt;
    logic                   follow_bit, follow_bit_nxt;
    logic                   ret_done, ret_done_nxt;
    logic                   err, err_nxt;

    logic                   illegal;
    logic [FREQ_BITS:0]     rem_sh;
    logic                   shift_en;
    logic [CODE_BITS-1:0]   sub_amt;

    assign illegal = (range_in == '0) ||
                     (lower_bound_in >= upper_bound_in) ||
                     (upper_bound_in > range_in);

    // Partial remainder always stays below the divisor, so FREQ_BITS+1 bits hold the shifted value.
    assign rem_sh = {rem, dvd[CODE_BITS]};

    always_comb begin
        state_nxt      = state;
        low_nxt        = low;
        high_nxt       = high;
        pending_nxt    = pending;
        lo_f_nxt       = lo_f;
        hi_f_nxt       = hi_f;
        tot_f_nxt      = tot_f;
        dvd_nxt        = dvd;
        quot_nxt       = quot;
        rem_nxt        = rem;
        cnt_nxt        = cnt;
        cur_bit_nxt    = cur_bit;
        follow_bit_nxt = follow_bit;
        ret_done_nxt   = ret_done;
        err_nxt        = err;
        shift_en       = 1'b0;
        sub_amt        = '0;

        case (state)
            S_IDLE: begin
                if (valid_in) begin
                    if (illegal) begin
                        err_nxt = 1'b1;
                    end else begin
                        lo_f_nxt  = lower_bound_in;
                        hi_f_nxt  = upper_bound_in;
                        tot_f_nxt = range_in;
                        dvd_nxt   = {1'b0, high} - {1'b0, low} + {{CODE_BITS{1'b0}}, 1'b1};
                        quot_nxt  = '0;
                        rem_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = S_DIVIDE;
                    end
                end else if (flush_in) begin
                    state_nxt = S_FLUSH;
                end
            end

            S_DIVIDE: begin
                if (rem_sh >= {1'b0, tot_f}) begin
                    rem_nxt  = FREQ_BITS'(rem_sh - {1'b0, tot_f});
                    quot_nxt = {quot[CODE_BITS-1:0], 1'b1};
                end else begin
                    rem_nxt  = rem_sh[FREQ_BITS-1:0];
                    quot_nxt = {quot[CODE_BITS-1:0], 1'b0};
                end
                dvd_nxt = {dvd[CODE_BITS-1:0], 1'b0};
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(CODE_BITS)) begin
                    state_nxt = S_UPDATE;
                end
            end

            S_UPDATE: begin
                // Modular arithmetic: truncation to CODE_BITS gives the exact result under the range invariant.
                high_nxt  = low + CODE_BITS'(quot * (CODE_BITS+1)'(hi_f)) - CODE_BITS'(1);
                low_nxt   = low + CODE_BITS'(quot * (CODE_BITS+1)'(lo_f));
                state_nxt = S_RENORM;
            end

            S_RENORM: begin
                if (high < HALF) begin
                    cur_bit_nxt    = 1'b0;
                    follow_bit_nxt = 1'b1;
                    ret_done_nxt   = 1'b0;
                    shift_en       = 1'b1;
                    state_nxt      = S_EMIT;
                end else if (low >= HALF) begin
                    cur_bit_nxt    = 1'b1;
                    follow_bit_nxt = 1'b0;
                    ret_done_nxt   = 1'b0;
                    sub_amt        = HALF;
                    shift_en       = 1'b1;
                    state_nxt      = S_EMIT;
                end else if ((low >= QUARTER) && (high < THREE_Q)) begin
                    pending_nxt = pending + CODE_BITS'(1);
                    sub_amt     = QUARTER;
                    shift_en    = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
                if (shift_en) begin
                    low_nxt  = (low - sub_amt) << 1;
                    high_nxt = ((high - sub_amt) << 1) | CODE_BITS'(1);
                end
            end

            S_EMIT: begin
                // pending doubles as the count of follow bits still owed; it reaches zero on exit.
                if (bit_ready_in) begin
                    if (pending == '0) begin
                        state_nxt = ret_done ? S_DONE : S_RENORM;
                    end else begin
                        pending_nxt = pending - CODE_BITS'(1);
                        cur_bit_nxt = follow_bit;
                    end
                end
            end

            S_FLUSH: begin
                pending_nxt    = pending + CODE_BITS'(1);
                cur_bit_nxt    = (low >= QUARTER);
                follow_bit_nxt = (low < QUARTER);
                ret_done_nxt   = 1'b1;
                state_nxt      = S_EMIT;
            end

            S_DONE: begin
                low_nxt     = '0;
                high_nxt    = ALL_ONES;
                pending_nxt = '0;
                state_nxt   = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            low        <= '0;
            high       <= ALL_ONES;
            pending    <= '0;
            lo_f       <= '0;
            hi_f       <= '0;
            tot_f      <= '0;
            dvd        <= '0;
            quot       <= '0;
            rem        <= '0;
            cnt        <= '0;
            cur_bit    <= 1'b0;
            follow_bit <= 1'b0;
            ret_done   <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            low        <= low_nxt;
            high       <= high_nxt;
            pending    <= pending_nxt;
            lo_f       <= lo_f_nxt;
            hi_f       <= hi_f_nxt;
            tot_f      <= tot_f_nxt;
            dvd        <= dvd_nxt;
            quot       <= quot_nxt;
            rem        <= rem_nxt;
            cnt        <= cnt_nxt;
            cur_bit    <= cur_bit_nxt;
            follow_bit <= follow_bit_nxt;
            ret_done   <= ret_done_nxt;
            err        <= err_nxt;
        end
    end

    // ready_out is gated by rst so it reads 0 for the whole reset window.
    assign ready_out     = rst && (state == S_IDLE);
    assign bit_valid_out = (state == S_EMIT);
    assign bit_out       = (state == S_EMIT) && cur_bit;
    assign done_out      = (state == S_DONE);
    assign error_out     = err;

endmodule

// File: tb/tb_arith_interval_coder.sv
module tb_arith_interval_coder;

    logic        clk;
    logic        rst;
    logic [15:0] lower_bound_in;
    logic [15:0] upper_bound_in;
    logic [15:0] range_in;
    logic        valid_in;
    logic        ready_out;
    logic        flush_in;
    logic        bit_out;
    logic        bit_valid_out;
    logic        bit_ready_in;
    logic        done_out;
    logic        error_out;

    arith_interval_coder #(.CODE_BITS(32), .FREQ_BITS(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .lower_bound_in (lower_bound_in),
        .upper_bound_in (upper_bound_in),
        .range_in       (range_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .flush_in       (flush_in),
        .bit_out        (bit_out),
        .bit_valid_out  (bit_valid_out),
        .bit_ready_in   (bit_ready_in),
        .done_out       (done_out),
        .error_out      (error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks;
    int   errors;
    int   done_cnt;
    logic exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed bit handshake is compared against the scoreboard queue.
    always @(negedge clk) begin
        if (rst && bit_valid_out && bit_ready_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bit: got %0b expected no bit", bit_out);
            end else begin
                check("bit_value", {63'd0, bit_out}, {63'd0, exp_q.pop_front()});
            end
        end
        if (rst && done_out) done_cnt++;
    end

    task automatic wait_ready(output int cyc);
        cyc = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (ready_out) break;
        end
        if (!ready_out) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready_out=0 expected 1");
        end
    endtask

    task automatic send(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] tot);
        int c;
        wait_ready(c);
        lower_bound_in = lo;
        upper_bound_in = hi;
        range_in       = tot;
        valid_in       = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic send_flush();
        int c;
        wait_ready(c);
        flush_in = 1'b1;
        @(posedge clk);
        #1 flush_in = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic check_drained(input string name);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    int cyc;
    int d0;

    initial begin
        checks = 0; errors = 0; done_cnt = 0;
        rst = 1'b0; valid_in = 1'b0; flush_in = 1'b0; bit_ready_in = 1'b1;
        lower_bound_in = '0; upper_bound_in = '0; range_in = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready", {63'd0, ready_out}, 64'd0);
        check("rst_bit_valid", {63'd0, bit_valid_out}, 64'd0);
        check("rst_bit", {63'd0, bit_out}, 64'd0);
        check("rst_done", {63'd0, done_out}, 64'd0);
        check("rst_error", {63'd0, error_out}, 64'd0);
        check("rst_low", 64'(dut.low), 64'h0);
        check("rst_high", 64'(dut.high), 64'hFFFF_FFFF);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("idle_ready", {63'd0, ready_out}, 64'd1);

        // (0,1,2): one bit 0, ready back 37 edges after acceptance (36 + handshake)
        exp_q.push_back(1'b0);
        send(16'd0, 16'd1, 16'd2);
        wait_ready(cyc);
        check("t012_latency", 64'(cyc), 64'd37);
        check_drained("t012_drained");
        check("t012_low", 64'(dut.low), 64'h0);
        check("t012_high", 64'(dut.high), 64'hFFFF_FFFF);

        // (1,2,2) from reset: one bit 1, full range restored
        do_reset();
        exp_q.push_back(1'b1);
        send(16'd1, 16'd2, 16'd2);
        wait_ready(cyc);
        check_drained("t122_drained");
        check("t122_low", 64'(dut.low), 64'h0);
        check("t122_high", 64'(dut.high), 64'hFFFF_FFFF);

        // (1,3,4) then flush: no bits, pending=1, flush emits 0,1,1 and one done pulse
        do_reset();
        send(16'd1, 16'd3, 16'd4);
        wait_ready(cyc);
        check("t134_latency", 64'(cyc), 64'd36);
        check_drained("t134_nobits");
        check("t134_pending", 64'(dut.pending), 64'd1);
        check("t134_low", 64'(dut.low), 64'h0);
        check("t134_high", 64'(dut.high), 64'hFFFF_FFFF);
        d0 = done_cnt;
        exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        send_flush();
        wait_ready(cyc);
        check_drained("flush134_drained");
        check("flush134_done", 64'(done_cnt - d0), 64'd1);
        check("flush134_pending", 64'(dut.pending), 64'd0);

        // (0,2,3): no renormalization, ready back after 35 edges; flush emits 0,1
        do_reset();
        send(16'd0, 16'd2, 16'd3);
        wait_ready(cyc);
        check("t023_latency", 64'(cyc), 64'd35);
        check("t023_high", 64'(dut.high), 64'hAAAA_AAA9);
        d0 = done_cnt;
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        send_flush();
        wait_ready(cyc);
        check_drained("flush023_drained");
        check("flush023_done", 64'(done_cnt - d0), 64'd1);
        check("flush023_high", 64'(dut.high), 64'hFFFF_FFFF);

        // Illegal triple (5,5,8): sticky error, ready stays high, no state change
        do_reset();
        send(16'd5, 16'd5, 16'd8);
        @(negedge clk);
        check("ill_error", {63'd0, error_out}, 64'd1);
        check("ill_ready", {63'd0, ready_out}, 64'd1);
        check("ill_low", 64'(dut.low), 64'h0);
        check("ill_high", 64'(dut.high), 64'hFFFF_FFFF);
        exp_q.push_back(1'b0);
        send(16'd0, 16'd1, 16'd2);
        wait_ready(cyc);
        check_drained("ill_next_drained");
        check("ill_sticky", {63'd0, error_out}, 64'd1);

        // Other illegal forms: upper > range, range == 0
        do_reset();
        @(negedge clk);
        check("err_cleared", {63'd0, error_out}, 64'd0);
        send(16'd0, 16'd3, 16'd2);
        @(negedge clk);
        check("ill_up_gt_range", {63'd0, error_out}, 64'd1);
        do_reset();
        send(16'd0, 16'd1, 16'd0);
        @(negedge clk);
        check("ill_range0", {63'd0, error_out}, 64'd1);

        // Stall: bit held stable for 10 cycles with bit_ready_in low
        do_reset();
        bit_ready_in = 1'b0;
        exp_q.push_back(1'b0);
        send(16'd0, 16'd1, 16'd2);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bit_valid_out) break;
        end
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", {63'd0, bit_valid_out}, 64'd1);
            check("stall_bit", {63'd0, bit_out}, 64'd0);
            @(negedge clk);
        end
        check("stall_not_taken", 64'(exp_q.size()), 64'd1);
        @(posedge clk);
        #1 bit_ready_in = 1'b1;
        wait_ready(cyc);
        check_drained("stall_drained");

        // Reset mid-DIVIDE: outputs return to reset values in the same cycle
        do_reset();
        send(16'd1, 16'd2, 16'd2);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_ready", {63'd0, ready_out}, 64'd0);
        check("mid_rst_bit_valid", {63'd0, bit_valid_out}, 64'd0);
        check("mid_rst_done", {63'd0, done_out}, 64'd0);
        check("mid_rst_error", {63'd0, error_out}, 64'd0);
        check("mid_rst_state", 64'(dut.state), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.push_back(1'b1);
        send(16'd1, 16'd2, 16'd2);
        wait_ready(cyc);
        check_drained("post_rst_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
